rt_track: RTL

- Cycle-accurate model of a parametrised racetrack nanowire bundle: DOMAINS magnetic domains per track, WIDTH parallel tracks shifted in lockstep.
- Single read/write access port at domain index ACCESS_POS.
- Multi-domain shift operations executed one domain per cycle by an FSM, with shift-offset tracking and out-of-range protection.
- Sits in the testbench racetrack memory model, replacing chains of single-bit per-cell models behind one request/response interface.

---
 rtl/rt_pkg.sv | 23 ++
 rtl/rt_domain_row.sv | 36 +++
 rtl/rt_track.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Shared types for the racetrack bundle model.
//   rt_op_e    : request opcodes carried on req_op
//   rt_state_e : control FSM states
//   FWD/BWD    : shift direction encodings carried on req_dir
package rt_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SHIFT = 2'd2,
    OP_RSVD  = 2'd3
  } rt_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } rt_state_e;

  localparam logic FWD = 1'b0;
  localparam logic BWD = 1'b1;

endpackage

// File: rtl/rt_domain_row.sv
// One domain position across all WIDTH tracks.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable, dir   : shift this position one step, direction FWD/BWD
//   fwd_in        : content of the lower-index neighbour (used on FWD)
//   bwd_in        : content of the higher-index neighbour (used on BWD)
//   wr_en, wdata  : access-port write
//   q             : stored domain content
module rt_domain_row
  import rt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [WIDTH-1:0] fwd_in,
  input  logic [WIDTH-1:0] bwd_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  // Writes and shifts never coincide: writes only happen while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr_en) begin
      q <= wdata;
    end else if (enable) begin
      q <= (dir == FWD) ? fwd_in : bwd_in;
    end
  end

endmodule

// File: rtl/rt_track.sv
// Racetrack nanowire bundle: DOMAINS positions x WIDTH tracks shifted in
// lockstep, one access port at ACCESS_POS, multi-step shifts run one domain
// per cycle with signed offset tracking and range protection.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only when idle)
//   req_op/dir/amt/wdata        : request payload
//   rsp_valid/rsp_rdata/rsp_err : single-cycle response pulse
//   offset                      : signed shift offset from reset position
//   busy                        : shift or response in progress
module rt_track
  import rt_pkg::*;
#(
  parameter  int unsigned DOMAINS    = 16,
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned ACCESS_POS = 8,
  parameter  int unsigned MAX_OFF    = 7,
  parameter  int unsigned AMT_W      = 4,
  localparam int unsigned OFF_W      = $clog2(2 * MAX_OFF + 1) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_dir,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [OFF_W-1:0] offset,
  output logic             busy
);

  // Wide enough for offset +/- amount without overflow.
  localparam int unsigned CW = OFF_W + AMT_W + 1;
  localparam logic signed [CW-1:0] LIMIT = CW'(MAX_OFF);

  rt_state_e        state, state_nxt;
  rt_op_e           op;
  logic [AMT_W-1:0] remain;
  logic             dir_q;
  logic             accept, shift_en, wr_en, range_err;
  logic signed [CW-1:0] off_ext, amt_ext, target;
  logic [WIDTH-1:0] dom [DOMAINS];

  assign op = rt_op_e'(req_op);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_SHIFT && !range_err && req_amt != '0) state_nxt = ST_SHIFT;
          else                                               state_nxt = ST_RESP;
        end
      end
      ST_SHIFT: if (remain == AMT_W'(1)) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State decode
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state == ST_SHIFT) || (state == ST_RESP);
    shift_en  = (state == ST_SHIFT);
    accept    = req_valid && req_ready;
    wr_en     = accept && (op == OP_WRITE);
  end

  // Range check of the offset the requested shift would reach
  always_comb begin
    off_ext   = CW'($signed(offset));
    amt_ext   = CW'({1'b0, req_amt});
    target    = (req_dir == BWD) ? off_ext - amt_ext : off_ext + amt_ext;
    range_err = (target > LIMIT) || (target < -LIMIT);
  end

  // Shift bookkeeping and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      offset    <= '0;
      remain    <= '0;
      dir_q     <= FWD;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == ST_RESP);
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        case (op)
          OP_READ:  rsp_rdata <= dom[ACCESS_POS];
          OP_SHIFT: begin
            rsp_err <= range_err;
            remain  <= req_amt;
            dir_q   <= req_dir;
          end
          OP_RSVD:  rsp_err <= 1'b1;
          default:  ;
        endcase
      end
      if (shift_en) begin
        remain <= remain - AMT_W'(1);
        offset <= (dir_q == BWD) ? offset - OFF_W'(1) : offset + OFF_W'(1);
      end
    end
  end

  // Domain array; end positions take zeros on the side data enters from.
  for (genvar i = 0; i < DOMAINS; i++) begin : g_row
    logic [WIDTH-1:0] fwd_in, bwd_in;

    if (i == 0) begin : g_fwd_edge
      assign fwd_in = '0;
    end else begin : g_fwd_link
      assign fwd_in = dom[i-1];
    end

    if (i == DOMAINS - 1) begin : g_bwd_edge
      assign bwd_in = '0;
    end else begin : g_bwd_link
      assign bwd_in = dom[i+1];
    end

    rt_domain_row #(.WIDTH(WIDTH)) u_row (
      .clk    (clk),
      .rst    (rst),
      .enable (shift_en),
      .dir    (dir_q),
      .fwd_in (fwd_in),
      .bwd_in (bwd_in),
      .wr_en  (wr_en && (i == ACCESS_POS)),
      .wdata  (req_wdata),
      .q      (dom[i])
    );
  end

endmodule
